// File: rtl/beat_sequencer_if.sv
// Control/status bundle between the user-control front end and the beat
// sequencer. The master side issues command pulses and loop/tempo settings.
// The slave side (the sequencer) returns the beat index and its status.
interface beat_sequencer_if #(
    parameter int BEAT_W = 8,
    parameter int DIV_W  = 24
);
    // Commands are single-cycle pulses sampled on the rising clock edge.
    // Levels and settings are sampled every cycle and may change at any time.
    // There is no back-pressure: the sequencer acts on a pulse in the cycle it is seen.
    logic              play;
    logic              pause;
    logic              stop;
    logic              loop;
    logic [BEAT_W-1:0] loop_start;
    logic [BEAT_W-1:0] loop_end;
    logic [DIV_W-1:0]  tempo_div;

    logic [BEAT_W-1:0] beat;
    logic              beat_tick;
    logic              playing;
    logic              done;
    logic [1:0]        dbg_state;   // raw FSM state, for observation only

    modport master (
        output play, pause, stop, loop, loop_start, loop_end, tempo_div,
        input  beat, beat_tick, playing, done, dbg_state
    );

    modport slave (
        input  play, pause, stop, loop, loop_start, loop_end, tempo_div,
        output beat, beat_tick, playing, done, dbg_state
    );
endinterface

// File: rtl/beat_sequencer.sv
// Beat sequencer: produces the music ROM beat address with a programmable
// tempo prescaler, play/pause/stop control and an optional loop region.
module beat_sequencer #(
    parameter int BEAT_W   = 8,
    parameter int BEAT_LEN = 64,
    parameter int DIV_W    = 24
) (
    input logic          clk,
    input logic          rst,
    beat_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One extra bit so a song that fills the whole index space still compares correctly.
    localparam logic [BEAT_W:0]   LEN_EXT   = (BEAT_W + 1)'(BEAT_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEAT_LEN - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [DIV_W-1:0]  presc_q, presc_d;
    logic              beat_tick_q, beat_tick_d;

    logic [DIV_W-1:0]  div_last;
    logic              region_valid;
    logic              loop_ok;

    // Effective divider and loop-region qualification, re-evaluated every cycle.
    always_comb begin
        div_last     = (bus.tempo_div == '0) ? '0 : (bus.tempo_div - DIV_ONE);
        region_valid = (bus.loop_start <= bus.loop_end) &&
                       ({1'b0, bus.loop_end} < LEN_EXT);
        loop_ok      = bus.loop && region_valid;
    end

    // Next-state, beat and prescaler logic; stop beats play, play beats pause.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        presc_d     = presc_q;
        beat_tick_d = 1'b0;

        if (bus.stop) begin
            state_d = ST_IDLE;
            beat_d  = '0;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.play) begin
                        state_d = ST_PLAY;
                        beat_d  = loop_ok ? bus.loop_start : '0;
                        presc_d = '0;
                    end
                end
                ST_PAUSE: begin
                    // Resume keeps both the beat and the partial prescaler count.
                    if (bus.play) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (bus.pause && !bus.play) begin
                        state_d = ST_PAUSE;
                    end else if (presc_q >= div_last) begin
                        // >= lets a live tempo decrease wrap on the next compare.
                        presc_d = '0;
                        if (loop_ok && (beat_q == bus.loop_end)) begin
                            beat_d      = bus.loop_start;
                            beat_tick_d = 1'b1;
                        end else if (beat_q == LAST_BEAT) begin
                            if (bus.loop) begin
                                beat_d      = region_valid ? bus.loop_start : '0;
                                beat_tick_d = 1'b1;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            beat_d      = beat_q + 1'b1;
                            beat_tick_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + DIV_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                    presc_d = '0;
                end
            endcase
        end
    end

    // State, beat, prescaler and tick registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            presc_q     <= '0;
            beat_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            presc_q     <= presc_d;
            beat_tick_q <= beat_tick_d;
        end
    end

    // Status is decoded purely from registered state.
    assign bus.beat      = beat_q;
    assign bus.beat_tick = beat_tick_q;
    assign bus.playing   = (state_q == ST_PLAY);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer: a 64-beat instance for most scenarios and a
// 4-beat instance for the end-of-song behaviour.
module tb_beat_sequencer;
    logic clk = 1'b0;
    logic rst;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    beat_sequencer_if #(.BEAT_W(8), .DIV_W(24)) bus ();
    beat_sequencer_if #(.BEAT_W(8), .DIV_W(24)) bus4 ();

    beat_sequencer #(.BEAT_W(8), .BEAT_LEN(64), .DIV_W(24)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    beat_sequencer #(.BEAT_W(8), .BEAT_LEN(4), .DIV_W(24)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic init_inputs();
        bus.play = 0; bus.pause = 0; bus.stop = 0; bus.loop = 0;
        bus.loop_start = 0; bus.loop_end = 0; bus.tempo_div = 1;
        bus4.play = 0; bus4.pause = 0; bus4.stop = 0; bus4.loop = 0;
        bus4.loop_start = 0; bus4.loop_end = 0; bus4.tempo_div = 1;
    endtask

    task automatic pulse(input bit p, input bit pa, input bit s);
        bus.play = p; bus.pause = pa; bus.stop = s;
        @(negedge clk);
        bus.play = 0; bus.pause = 0; bus.stop = 0;
    endtask

    task automatic pulse4(input bit p, input bit pa, input bit s);
        bus4.play = p; bus4.pause = pa; bus4.stop = s;
        @(negedge clk);
        bus4.play = 0; bus4.pause = 0; bus4.stop = 0;
    endtask

    task automatic wait_tick(input int budget, output int waited, output bit seen);
        seen = 0; waited = 0;
        while (!seen && waited < budget) begin
            @(negedge clk);
            waited++;
            if (bus.beat_tick === 1'b1) seen = 1;
        end
    endtask

    task automatic wait_tick4(input int budget, output int waited, output bit seen);
        seen = 0; waited = 0;
        while (!seen && waited < budget) begin
            @(negedge clk);
            waited++;
            if (bus4.beat_tick === 1'b1) seen = 1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1; init_inputs();
        cyc(3);
        rst = 0;
        vectors++;
        if (bus.beat !== 8'd0 || bus.playing !== 1'b0 || bus.done !== 1'b0 || bus.beat_tick !== 1'b0) begin
            $display("FAIL reset_init: beat=%0d playing=%b done=%b tick=%b expected 0/0/0/0",
                     bus.beat, bus.playing, bus.done, bus.beat_tick);
            miscompares++;
        end
        bus.tempo_div = 1;
        pulse(1, 0, 0);
        cyc(17);
        vectors++;
        if (bus.beat !== 8'd17 || bus.playing !== 1'b1) begin
            $display("FAIL reset_run17: beat=%0d playing=%b expected 17/1", bus.beat, bus.playing);
            miscompares++;
        end
        rst = 1;
        cyc(2);
        rst = 0;
        vectors++;
        if (bus.beat !== 8'd0 || bus.playing !== 1'b0 || bus.done !== 1'b0 || bus.beat_tick !== 1'b0) begin
            $display("FAIL reset_midplay: beat=%0d playing=%b done=%b tick=%b expected 0/0/0/0",
                     bus.beat, bus.playing, bus.done, bus.beat_tick);
            miscompares++;
        end
        cyc(3);
        vectors++;
        if (bus.beat !== 8'd0 || bus.playing !== 1'b0) begin
            $display("FAIL reset_stays_idle: beat=%0d playing=%b expected 0/0", bus.beat, bus.playing);
            miscompares++;
        end
    endtask

    task automatic test_song_end();
        int w; bit s; int ticks;
        bus4.tempo_div = 3; bus4.loop = 0;
        pulse4(1, 0, 0);
        vectors++;
        if (bus4.beat !== 8'd0 || bus4.playing !== 1'b1) begin
            $display("FAIL end_start: beat=%0d playing=%b expected 0/1", bus4.beat, bus4.playing);
            miscompares++;
        end
        for (int b = 1; b <= 3; b++) exp_q.push_back(8'(b));
        for (int i = 0; i < 3; i++) begin
            wait_tick4(10, w, s);
            vectors++;
            if (!s) begin
                $display("FAIL end_tick_timeout: got none within 10 expected tick %0d", i);
                miscompares++;
            end else begin
                exp_b = exp_q.pop_front();
                if (bus4.beat !== exp_b || w != 3) begin
                    $display("FAIL end_tick: beat=%0d after %0d cycles expected %0d after 3",
                             bus4.beat, w, exp_b);
                    miscompares++;
                end
            end
        end
        ticks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus4.beat_tick === 1'b1) ticks++;
        end
        vectors++;
        if (ticks != 0 || bus4.done !== 1'b1 || bus4.beat !== 8'd3 || bus4.playing !== 1'b0) begin
            $display("FAIL end_done: ticks=%0d done=%b beat=%0d playing=%b expected 0/1/3/0",
                     ticks, bus4.done, bus4.beat, bus4.playing);
            miscompares++;
        end
        pulse4(0, 1, 0);
        vectors++;
        if (bus4.done !== 1'b1 || bus4.beat !== 8'd3) begin
            $display("FAIL end_pause_ignored: done=%b beat=%0d expected 1/3", bus4.done, bus4.beat);
            miscompares++;
        end
        pulse4(1, 0, 0);
        vectors++;
        if (bus4.playing !== 1'b1 || bus4.done !== 1'b0 || bus4.beat !== 8'd0) begin
            $display("FAIL end_replay: playing=%b done=%b beat=%0d expected 1/0/0",
                     bus4.playing, bus4.done, bus4.beat);
            miscompares++;
        end
        pulse4(0, 0, 1);
    endtask

    task automatic test_loop();
        int w; bit s; int n;
        pulse(0, 0, 1);
        bus.tempo_div = 2; bus.loop = 0; bus.loop_start = 2; bus.loop_end = 4;
        pulse(1, 0, 0);
        bus.loop = 1;
        vectors++;
        if (bus.beat !== 8'd0) begin
            $display("FAIL loop_start_beat: beat=%0d expected 0", bus.beat);
            miscompares++;
        end
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4);
        exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(2);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            wait_tick(5, w, s);
            vectors++;
            if (!s) begin
                $display("FAIL loop_tick_timeout: got none within 5 expected tick %0d", i);
                miscompares++;
            end else begin
                exp_b = exp_q.pop_front();
                if (bus.beat !== exp_b || w != 2) begin
                    $display("FAIL loop_tick: beat=%0d after %0d cycles expected %0d after 2",
                             bus.beat, w, exp_b);
                    miscompares++;
                end
            end
        end
        // Invalid region: run to the last beat, then wrap to 0.
        bus.loop_end = 1;
        for (int b = 3; b <= 63; b++) exp_q.push_back(8'(b));
        exp_q.push_back(0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            wait_tick(5, w, s);
            vectors++;
            if (!s) begin
                $display("FAIL loop_inval_timeout: got none within 5 expected tick %0d", i);
                miscompares++;
            end else begin
                exp_b = exp_q.pop_front();
                if (bus.beat !== exp_b || w != 2) begin
                    $display("FAIL loop_inval_tick: beat=%0d after %0d cycles expected %0d after 2",
                             bus.beat, w, exp_b);
                    miscompares++;
                end
            end
        end
        pulse(0, 0, 1);
        bus.loop_end = 4;
        pulse(1, 0, 0);
        vectors++;
        if (bus.beat !== 8'd2 || bus.playing !== 1'b1) begin
            $display("FAIL loop_play_at_start: beat=%0d playing=%b expected 2/1", bus.beat, bus.playing);
            miscompares++;
        end
        pulse(0, 0, 1);
        bus.loop = 0;
    endtask

    task automatic test_pause_resume();
        int w; bit s; int ticks;
        bus.tempo_div = 4; bus.loop = 0;
        pulse(1, 0, 0);
        for (int b = 1; b <= 5; b++) exp_q.push_back(8'(b));
        for (int i = 0; i < 5; i++) begin
            wait_tick(8, w, s);
            vectors++;
            if (!s) begin
                $display("FAIL pause_tick_timeout: got none within 8 expected tick %0d", i);
                miscompares++;
            end else begin
                exp_b = exp_q.pop_front();
                if (bus.beat !== exp_b || w != 4) begin
                    $display("FAIL pause_run_tick: beat=%0d after %0d cycles expected %0d after 4",
                             bus.beat, w, exp_b);
                    miscompares++;
                end
            end
        end
        cyc(1);                 // prescaler now at 1
        pulse(0, 1, 0);
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.beat_tick === 1'b1) ticks++;
        end
        vectors++;
        if (ticks != 0 || bus.beat !== 8'd5 || bus.playing !== 1'b0) begin
            $display("FAIL pause_hold: ticks=%0d beat=%0d playing=%b expected 0/5/0",
                     ticks, bus.beat, bus.playing);
            miscompares++;
        end
        pulse(1, 0, 0);
        exp_q.push_back(6);
        wait_tick(8, w, s);
        vectors++;
        if (!s) begin
            $display("FAIL resume_timeout: got none within 8 expected beat 6");
            miscompares++;
        end else begin
            exp_b = exp_q.pop_front();
            if (bus.beat !== exp_b || w != 3) begin
                $display("FAIL resume_tick: beat=%0d after %0d cycles expected %0d after 3",
                         bus.beat, w, exp_b);
                miscompares++;
            end
        end
    endtask

    task automatic test_priority();
        pulse(1, 1, 1);
        vectors++;
        if (bus.playing !== 1'b0 || bus.beat !== 8'd0 || bus.done !== 1'b0 || bus.dbg_state !== 2'd0) begin
            $display("FAIL prio_stop: playing=%b beat=%0d done=%b state=%0d expected 0/0/0/idle",
                     bus.playing, bus.beat, bus.done, bus.dbg_state);
            miscompares++;
        end
        pulse(0, 1, 0);
        vectors++;
        if (bus.playing !== 1'b0 || bus.beat !== 8'd0) begin
            $display("FAIL prio_pause_idle: playing=%b beat=%0d expected 0/0", bus.playing, bus.beat);
            miscompares++;
        end
        pulse(1, 1, 0);
        vectors++;
        if (bus.playing !== 1'b1 || bus.beat !== 8'd0) begin
            $display("FAIL prio_play_over_pause: playing=%b beat=%0d expected 1/0", bus.playing, bus.beat);
            miscompares++;
        end
        pulse(0, 0, 1);
    endtask

    task automatic test_tempo();
        int w; bit s;
        bus.tempo_div = 0; bus.loop = 0;
        pulse(1, 0, 0);
        for (int b = 1; b <= 5; b++) exp_q.push_back(8'(b));
        for (int i = 0; i < 5; i++) begin
            wait_tick(3, w, s);
            vectors++;
            if (!s) begin
                $display("FAIL div0_timeout: got none within 3 expected tick %0d", i);
                miscompares++;
            end else begin
                exp_b = exp_q.pop_front();
                if (bus.beat !== exp_b || w != 1) begin
                    $display("FAIL div0_tick: beat=%0d after %0d cycles expected %0d after 1",
                             bus.beat, w, exp_b);
                    miscompares++;
                end
            end
        end
        pulse(0, 0, 1);
        bus.tempo_div = 100;
        pulse(1, 0, 0);
        cyc(50);                // prescaler at 50
        vectors++;
        if (bus.beat !== 8'd0) begin
            $display("FAIL div100_hold: beat=%0d expected 0", bus.beat);
            miscompares++;
        end
        bus.tempo_div = 4;
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        for (int i = 0; i < 3; i++) begin
            wait_tick(8, w, s);
            vectors++;
            if (!s) begin
                $display("FAIL retempo_timeout: got none within 8 expected tick %0d", i);
                miscompares++;
            end else begin
                exp_b = exp_q.pop_front();
                if (bus.beat !== exp_b || w != ((i == 0) ? 1 : 4)) begin
                    $display("FAIL retempo_tick: beat=%0d after %0d cycles expected %0d after %0d",
                             bus.beat, w, exp_b, (i == 0) ? 1 : 4);
                    miscompares++;
                end
            end
        end
        pulse(0, 0, 1);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_song_end();
        test_loop();
        test_pause_resume();
        test_priority();
        test_tempo();
        vectors++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
